// File: rtl/geofence_feeder.sv
// geofence_feeder: ping-pong buffers receiver triples into the geofence core and queues its verdicts
module geofence_feeder #(
    parameter int IDW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [9:0]     in_x,
    input  logic [9:0]     in_y,
    input  logic [10:0]    in_r,
    output logic           gf_reset,
    output logic [9:0]     gf_X,
    output logic [9:0]     gf_Y,
    output logic [10:0]    gf_R,
    input  logic           gf_valid,
    input  logic           gf_is_inside,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_inside,
    output logic [IDW-1:0] res_id
);
    typedef enum logic [1:0] {HOLD, SEND, WAIT} state_t;
    state_t state, state_n;
    logic run, wb, rb, wr, push, pop;
    logic [1:0] full, count, slot;
    logic [2:0] wp, k;
    logic [IDW-1:0] seq_id;
    logic [30:0] mem [2][6];
    logic [IDW:0] fifo [2];

    assign wr = in_valid && in_ready;
    assign push = (state == WAIT) && gf_valid;
    assign pop = res_valid && res_ready;
    assign in_ready = run && !full[wb];
    assign res_valid = count != 2'd0;
    assign {res_inside, res_id} = fifo[0];
    assign {gf_X, gf_Y, gf_R} = (state == SEND) ? mem[rb][k] : 31'd0;
    assign slot = count - 2'(pop);

    // next state: a set may only start when the FIFO is guaranteed a free slot at its verdict
    always_comb begin
        state_n = (state == HOLD) ? ((full[rb] && count <= 2'd1) ? SEND : HOLD)
                : (state == SEND) ? ((k == 3'd5) ? WAIT : SEND)
                : !gf_valid ? WAIT
                : (full[rb] && (count == 2'd0 || (count == 2'd1 && pop))) ? SEND : HOLD;
    end

    // triple storage, no reset needed: reads are gated by the full flags
    always_ff @(posedge clk) begin
        if (wr)
            mem[wb][wp] <= {in_x, in_y, in_r};
    end

    // sequencing, bank bookkeeping and core reset alignment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HOLD;
            gf_reset <= 1'b1;
            run      <= 1'b0;
            wb       <= 1'b0;
            rb       <= 1'b0;
            full     <= 2'b00;
            wp       <= 3'd0;
            k        <= 3'd0;
            seq_id   <= '0;
        end else begin
            state    <= state_n;
            gf_reset <= state_n == HOLD;
            run      <= 1'b1;
            k        <= (state == SEND && k != 3'd5) ? k + 3'd1 : 3'd0;
            if (wr) begin
                wp <= (wp == 3'd5) ? 3'd0 : wp + 3'd1;
                if (wp == 3'd5) begin
                    full[wb] <= 1'b1;
                    wb       <= !wb;
                end
            end
            if (state == SEND && k == 3'd5) begin
                full[rb] <= 1'b0;
                rb       <= !rb;
            end
            if (push)
                seq_id <= seq_id + 1'b1;
        end
    end

    // two-entry result FIFO, head always in slot 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= 2'd0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (pop)
                fifo[0] <= fifo[1];
            if (push)
                fifo[slot[0]] <= {gf_is_inside, seq_id};
        end
    end
endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: random traffic against a set-level model of the feeder and a model of the core
module tb_geofence_feeder;
    localparam int IDW = 2;

    logic clk = 1'b0, reset = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [9:0] in_x = '0, in_y = '0;
    logic [10:0] in_r = '0;
    logic gf_reset;
    logic [9:0] gf_X, gf_Y;
    logic [10:0] gf_R;
    logic gf_valid = 1'b0, gf_is_inside = 1'b0;
    logic res_valid, res_ready = 1'b0, res_inside;
    logic [IDW-1:0] res_id;

    geofence_feeder #(.IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_r(in_r),
        .gf_reset(gf_reset), .gf_X(gf_X), .gf_Y(gf_Y), .gf_R(gf_R),
        .gf_valid(gf_valid), .gf_is_inside(gf_is_inside),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_inside(res_inside), .res_id(res_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // model state: accepted triples awaiting capture, pending verdicts, set counters
    logic [30:0] trips[$];
    logic [IDW:0] res_q[$];
    logic [IDW-1:0] seq;
    logic [IDW:0] pend_val;
    int acc, freed, cnt, dly;
    bit pend_acc, pend_free, pend_push, pend_pop, prev_hold, prev_valid, prev_cond;

    task automatic model_clear();
        trips.delete();
        res_q.delete();
        seq = '0;
        acc = 0; freed = 0; cnt = 0; dly = 0;
        pend_acc = 0; pend_free = 0; pend_push = 0; pend_pop = 0;
        prev_hold = 0; prev_valid = 0; prev_cond = 0;
    endtask

    // one negedge: retire last edge's effects, compare, then drive the next cycle
    task automatic step(input int pv, input int pr);
        int fb;
        bit pushed;
        logic [30:0] t;
        if (pend_acc) acc++;
        if (pend_free) freed++;
        if (pend_pop) void'(res_q.pop_front());
        if (pend_push) res_q.push_back(pend_val);
        pend_acc = 0; pend_free = 0; pend_push = 0; pend_pop = 0;
        fb = acc / 6 - freed;
        pushed = 0;
        check("in_ready", in_ready, fb < 2);
        check("res_valid", res_valid, res_q.size() != 0);
        if (res_valid && res_q.size() != 0)
            check("res_head", {res_inside, res_id}, res_q[0]);
        if (prev_hold) check("hold_start", !gf_reset, prev_cond);
        if (prev_valid) check("b2b_start", !gf_reset, prev_cond);
        gf_valid = 1'b0;
        if (gf_reset) begin
            cnt = 0;
            check("idle_xyr", {gf_X, gf_Y, gf_R}, 0);
        end else if (cnt < 6) begin
            if (trips.size() == 0) check("trip_avail", 0, 1);
            else begin
                t = trips.pop_front();
                check("gf_xyr", {gf_X, gf_Y, gf_R}, t);
            end
            cnt++;
            if (cnt == 6) begin
                pend_free = 1;
                dly = $urandom_range(0, 3);
            end else if (cnt == 3 && $urandom_range(0, 3) == 0) begin
                gf_valid = 1'b1;
                gf_is_inside = 1'($urandom);
            end
        end else begin
            check("wait_xyr", {gf_X, gf_Y, gf_R}, 0);
            if (dly == 0) begin
                gf_valid = 1'b1;
                gf_is_inside = 1'($urandom);
                pend_push = 1;
                pend_val = {gf_is_inside, seq};
                seq = seq + 1'b1;
                cnt = 0;
                pushed = 1;
            end else dly--;
        end
        in_valid = $urandom_range(0, 99) < pv;
        in_x = 10'($urandom);
        in_y = 10'($urandom);
        in_r = 11'($urandom);
        if (in_valid && in_ready) begin
            pend_acc = 1;
            trips.push_back({in_x, in_y, in_r});
        end
        res_ready = $urandom_range(0, 99) < pr;
        pend_pop = res_valid && res_ready;
        prev_hold = gf_reset;
        prev_valid = pushed;
        prev_cond = gf_reset ? (fb > 0 && res_q.size() <= 1)
                             : (fb > 0 && (res_q.size() == 0 || (res_q.size() == 1 && pend_pop)));
    endtask

    task automatic check_reset_values();
        check("rst_gf_reset", gf_reset, 1);
        check("rst_xyr", {gf_X, gf_Y, gf_R}, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res", {res_valid, res_inside, res_id}, 0);
    endtask

    initial begin
        bit hit;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        for (int i = 0; i < 400; i++) begin @(negedge clk); step(70, 50); end
        for (int i = 0; i < 300; i++) begin @(negedge clk); step(80, 0); end
        for (int i = 0; i < 400; i++) begin @(negedge clk); step(100, 100); end
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            step(90, 60);
            hit = (cnt == 3) && !gf_reset;
        end
        check("reach_send", hit, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        gf_valid = 1'b0;
        in_valid = 1'b0;
        res_ready = 1'b0;
        #1 check_reset_values();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_hold", gf_reset, 1);
        for (int i = 0; i < 800; i++) begin @(negedge clk); step(60, 40); end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/geofence_feeder.md
# geofence_feeder

Streams receiver sets into the `geofence` core and collects its verdicts. Upstream logic writes (X, Y, R) triples into a ping-pong buffer of two 6-entry banks. The feeder controls the core's active-high reset to align the core's 6-cycle capture window, presents one triple per cycle, then waits for the core's `valid` pulse. Verdicts, each tagged with a sequence id, go into a 2-deep result FIFO for the downstream consumer.

## Interface
- `IDW`, default 4: width of the result sequence id.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream triple valid.
- `in_ready` out 1: feeder can accept a triple.
- `in_x` in 10, `in_y` in 10, `in_r` in 11: upstream receiver coordinates and distance.
- `gf_reset` out 1: drives the core's active-high `reset` input (registered).
- `gf_X` out 10, `gf_Y` out 10, `gf_R` out 11: drive the core's `X`, `Y`, `R` inputs.
- `gf_valid` in 1: the core's one-cycle `valid`.
- `gf_is_inside` in 1: the core's `is_inside`.
- `res_valid` out 1: FIFO head is valid.
- `res_ready` in 1: consumer pops the head.
- `res_inside` out 1: verdict at the FIFO head.
- `res_id` out IDW: sequence id at the FIFO head.

## Operation
- Buffer
  - Two banks of 6 entries, with a write bank `wb` and a read bank `rb`. Both are 0 at reset.
  - Each bank has a full flag.
  - `in_ready` = !full[wb].
  - A triple is written when `in_valid && in_ready`. The write pointer runs 0..5.
  - On writing index 5: set full[wb], toggle `wb`, clear the pointer.
- FSM states are HOLD, SEND and WAIT. The reset state is HOLD.
- HOLD
  - `gf_reset`=1.
  - Go to SEND when full[rb] && (fifo_count ≤ 1).
  - `gf_reset` is registered to 0 at that same edge.
- SEND
  - `gf_reset`=0. Counter `k` runs 0..5.
  - `gf_X`/`gf_Y`/`gf_R` = bank[rb][k].
  - At k=5: clear full[rb], toggle `rb`, go to WAIT.
  - Outside SEND, `gf_X`/`gf_Y`/`gf_R` = 0.
- WAIT
  - `gf_reset`=0. Wait for `gf_valid`.
  - On `gf_valid`: push {`gf_is_inside`, seq_id} into the FIFO and increment `seq_id` (wraps modulo 2^IDW).
  - Then, if full[rb] && (fifo_count_before == 0 || (fifo_count_before == 1 && pop this cycle)): go directly to SEND with k=0 and `gf_reset` held at 0.
  - Otherwise go to HOLD and register `gf_reset`=1.
- `gf_valid` seen in HOLD or SEND is a protocol error: it is ignored and nothing is pushed.
- Result FIFO
  - 2 entries. Push and pop in the same cycle are both honoured.
  - The start rule above guarantees a push never meets a full FIFO.
- A bank being filled never aliases the bank being read. A write to `wb` while SEND reads `rb` is allowed.

## Timing
- Reset values (async, while `reset`=0):
  - `gf_reset`=1, `in_ready`=0, `res_valid`=0, `res_inside`=0, `res_id`=0, `gf_X`/`gf_Y`/`gf_R`=0.
  - Internally: state HOLD, `k`=0, `wb`=`rb`=0, full flags cleared, `seq_id`=0, fifo_count=0.
- `in_ready`=1 from the first cycle after reset release.
- Core alignment: index 0 is driven in the first cycle with `gf_reset`=0 (or the cycle after `gf_valid`). The core samples indices 0..5 on six consecutive edges.
- Upstream-to-core latency: the 6th upstream accept at edge T gives HOLD→SEND at edge T+1. `gf_X`=entry0 during cycle T+1..T+2, and the last triple is driven in cycle T+6..T+7.
- `gf_valid` at edge V gives `res_valid`=1 in cycle V..V+1, provided the FIFO was empty.
- Back-to-back sets: zero idle cycles between `gf_valid` and the next SEND when the next bank is full and the FIFO has room.
- `seq_id` wraps from 2^IDW−1 to 0.
- `reset` asserted mid-SEND or mid-WAIT: everything returns to the reset values immediately, and partially written banks are discarded.

## Test plan
- Reset behaviour: assert `reset`=0 mid-SEND at k=3 → `gf_reset`=1, `gf_X`=0, `in_ready`=0. After release, `in_ready`=1 and the FSM is in HOLD.
- Single set: write (10,20,5),(30,40,6),…,(110,120,10), then model the core pulsing `gf_valid` with `gf_is_inside`=1 → `gf_reset` falls one cycle after the 6th accept. `gf_X` shows 10,30,…,110 on six consecutive cycles. Then `res_valid`=1, `res_inside`=1, `res_id`=0.
- Back-to-back: preload two sets and hold `res_ready`=1 → the second SEND starts the cycle after `gf_valid` with `gf_reset` staying 0. Ids read 0 then 1.
- Backpressure: `res_ready`=0 across three sets → two results are stored, the third set stays in HOLD with `gf_reset`=1, and `in_ready`=0 once both banks are full. Popping one result releases SEND.
- Buffer boundaries: write 12 triples with no core activity → `in_ready` drops after the 12th. The 13th `in_valid` is not accepted until a SEND frees a bank.
- Id wrap and protocol error, IDW=2: run 5 sets → ids 0,1,2,3,0. A spurious `gf_valid` during SEND pushes nothing.
